// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with full-scan debounce and press FSM.
module keypad_scan #(
  parameter int CLK_HZ    = 100000000,
  parameter int SCAN_HZ   = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       multi_key
);

  localparam int DWELL_RAW = CLK_HZ / SCAN_HZ;
  localparam int DWELL     = (DWELL_RAW < 4) ? 4 : DWELL_RAW;
  localparam int DW        = $clog2(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [3:0]    DEB_TGT    = 4'(DEB_SCANS);

  // Scan result = {kind, code}; code is forced to 0 unless kind is SINGLE
  localparam logic [1:0] K_NONE   = 2'd0;
  localparam logic [1:0] K_SINGLE = 2'd1;
  localparam logic [1:0] K_MULTI  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HELD  = 2'd1,
    S_MULTI = 2'd2
  } state_t;

  logic [3:0]    r_row_s1;
  logic [3:0]    r_row_s2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col;
  logic [15:0]   r_acc;
  logic [5:0]    r_prev;
  logic [3:0]    r_deb_cnt;
  logic [5:0]    r_stable;
  state_t        r_state;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_down;
  logic          r_multi;

  logic          w_sample;
  logic          w_scan_done;
  logic [15:0]   w_hits;
  logic [1:0]    w_cnt;
  logic [3:0]    w_first;
  logic [5:0]    w_res;
  logic [3:0]    w_deb_next;
  state_t        w_state_next;
  logic          w_fire;

  assign w_sample    = (r_dwell == DWELL_LAST);
  assign w_scan_done = w_sample && (r_col == 2'd3);
  assign col_n       = ~(4'b0001 << r_col);

  // Merge the column being sampled into the accumulated map, then classify
  always_comb begin
    w_hits  = r_acc;
    w_cnt   = 2'd0;
    w_first = 4'd0;
    for (int r = 0; r < 4; r++) begin
      w_hits[{r[1:0], r_col}] = ~r_row_s2[r];
    end
    for (int i = 0; i < 16; i++) begin
      if (w_hits[i]) begin
        if (w_cnt == 2'd0) w_first = 4'(i);
        if (w_cnt != 2'd2) w_cnt = w_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_res = {K_NONE, 4'd0};
    if (w_cnt == 2'd1)      w_res = {K_SINGLE, w_first};
    else if (w_cnt == 2'd2) w_res = {K_MULTI, 4'd0};
  end

  always_comb begin
    w_deb_next = 4'd1;
    if (w_res == r_prev) begin
      w_deb_next = (r_deb_cnt >= DEB_TGT) ? r_deb_cnt : r_deb_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_s1  <= 4'hF;
      r_row_s2  <= 4'hF;
      r_dwell   <= '0;
      r_col     <= 2'd0;
      r_acc     <= 16'd0;
      r_prev    <= {K_NONE, 4'd0};
      r_deb_cnt <= 4'd0;
      r_stable  <= {K_NONE, 4'd0};
    end else begin
      r_row_s1 <= row_n;
      r_row_s2 <= r_row_s1;
      if (w_sample) begin
        r_dwell <= '0;
        r_col   <= r_col + 2'd1;
        r_acc   <= (r_col == 2'd3) ? 16'd0 : w_hits;
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
      if (w_scan_done) begin
        r_prev    <= w_res;
        r_deb_cnt <= w_deb_next;
        if ((w_deb_next >= DEB_TGT) && (w_res != r_stable)) r_stable <= w_res;
      end
    end
  end

  // Roll-over and MULTI exits only return to a fresh press through NONE
  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_stable[5:4] == K_SINGLE) begin
          w_state_next = S_HELD;
          w_fire       = 1'b1;
        end else if (r_stable[5:4] == K_MULTI) begin
          w_state_next = S_MULTI;
        end
      end
      S_HELD: begin
        if (r_stable[5:4] == K_NONE)       w_state_next = S_IDLE;
        else if (r_stable[5:4] == K_MULTI) w_state_next = S_MULTI;
      end
      S_MULTI: begin
        if (r_stable[5:4] == K_NONE) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_multi     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_key_valid <= w_fire;
      if (w_fire) r_key_code <= r_stable[3:0];
      r_key_down  <= (w_state_next == S_HELD);
      r_multi     <= (w_state_next == S_MULTI);
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;
  assign multi_key = r_multi;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - randomized keypad scoreboard bench for keypad_scan.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic        multi_key;
  logic [15:0] keys = 16'd0;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  mon_exp;
  int          model_st = 0;
  bit          prev_long = 1'b1;

  always #5 clk = ~clk;

  keypad_scan #(.CLK_HZ(1000), .SCAN_HZ(100), .DEB_SCANS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down),
    .multi_key(multi_key)
  );

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [3:0] code_of(input logic [15:0] k);
    for (int i = 0; i < 16; i++) if (k[i]) return 4'(i);
    return 4'd0;
  endfunction

  // Key-set level model: a long hold settles into the stable state, a short one never does
  task automatic seg(input logic [15:0] k, input int len, input bit is_long);
    if (is_long) begin
      if ($countones(k) == 0) model_st = 0;
      else if ($countones(k) == 1) begin
        if (model_st == 0) begin
          model_st = 1;
          exp_q.push_back(code_of(k));
        end
      end else model_st = 2;
    end
    keys = k;
    repeat (len) @(negedge clk);
    chk("key_down_level", key_down, model_st == 1);
    chk("multi_key_level", multi_key, model_st == 2);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("not_both_down_and_multi", key_down & multi_key, 0);
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_code", key_code, 16);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("pulse_key_code", key_code, mon_exp);
          chk("pulse_key_down", key_down, 1);
        end
      end
    end
  end

  initial begin
    int         lat;
    logic [3:0] exp_col;
    logic [3:0] prevc;
    logic [15:0] k;
    int         a, b, t, len;
    bit         lng;

    repeat (3) @(negedge clk);
    chk("reset_col_n", col_n, 4'b1110);
    chk("reset_key_code", key_code, 0);
    chk("reset_key_valid", key_valid, 0);
    chk("reset_key_down", key_down, 0);
    chk("reset_multi_key", multi_key, 0);
    rst = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      exp_col = ~(4'b0001 << ((i / 10) % 4));
      chk("col_sequence", col_n, exp_col);
    end
    @(negedge clk);

    // Clean press aligned to the start of a scan
    prevc = col_n;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (col_n == 4'b1110 && prevc != 4'b1110) break;
      prevc = col_n;
    end
    exp_q.push_back(4'd9);
    model_st = 1;
    keys = 16'h0200;
    lat = 0;
    while (!key_valid && lat < 260) begin
      @(negedge clk);
      lat++;
    end
    chk("press_latency_in_160_203", (lat >= 160 && lat <= 203), 1);
    chk("press_key_down", key_down, 1);
    keys = 16'd0;
    lat = 0;
    while (key_down && lat < 260) begin
      @(negedge clk);
      lat++;
    end
    chk("release_within_203", (lat <= 203), 1);
    model_st = 0;
    seg(16'd0, 100, 1'b1);

    // Bounce then hold
    exp_q.push_back(4'd3);
    model_st = 1;
    for (int i = 0; i < 150; i += 7) begin
      keys[3] = ~keys[3];
      repeat (7) @(negedge clk);
    end
    seg(16'h0008, 300, 1'b1);
    seg(16'd0, 300, 1'b1);

    // Hold and roll-over
    seg(16'h0020, 2000, 1'b1);
    seg(16'h0420, 300, 1'b1);
    seg(16'h0400, 300, 1'b1);
    seg(16'd0, 300, 1'b1);
    seg(16'h0400, 300, 1'b1);
    seg(16'd0, 300, 1'b1);

    // Reset while held
    seg(16'h8000, 300, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_col_n", col_n, 4'b1110);
    chk("midreset_key_down", key_down, 0);
    chk("midreset_key_code", key_code, 0);
    rst = 1'b0;
    model_st = 0;
    seg(16'h8000, 300, 1'b1);
    seg(16'd0, 300, 1'b1);

    // Short glitch
    seg(16'h0040, 60, 1'b0);
    seg(16'd0, 300, 1'b1);

    for (int s = 0; s < 36; s++) begin
      t = $urandom_range(0, 99);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      if (t < 25)      k = 16'd0;
      else if (t < 70) k = 16'h0001 << a;
      else             k = (16'h0001 << a) | (16'h0001 << b);
      lng = !prev_long || ($urandom_range(0, 99) >= 20);
      len = lng ? $urandom_range(240, 400) : $urandom_range(20, 60);
      seg(k, len, lng);
      prev_long = lng;
    end
    seg(16'd0, 300, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
